// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue.
// Streams sequential instruction words from memory ahead of the CPU. It keeps
// up to DEPTH words buffered or in flight. The CPU fetches from the head of
// the queue. A fetch to any address other than the next expected word
// restarts the stream at that address. Responses to reads issued before the
// restart are dropped as they arrive.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   cpu_address/read    : CPU fetch request (address bits [1:0] ignored)
//   cpu_waitrequest     : request not accepted this cycle
//   cpu_readdatavalid   : cpu_readdata holds a word, one cycle after a hit
//   cpu_readdata        : fetched instruction word
//   mem_address/read    : word-aligned memory read request
//   mem_waitrequest     : memory stalls the request
//   mem_readdatavalid   : memory response valid (responses arrive in order)
//   mem_readdata        : memory response data
module instruction_prefetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  output logic        cpu_waitrequest,
  output logic        cpu_readdatavalid,
  output logic [31:0] cpu_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [31:0] mem_readdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [29:0]   tagMem_q  [DEPTH];
  logic [31:0]   dataMem_q [DEPTH];
  logic [AW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          streamValid_q, streamValid_d;
  logic [29:0]   fetchAddr_q, fetchAddr_d;
  logic [29:0]   fillTag_q, fillTag_d;
  logic          cpuValid_q;
  logic [31:0]   cpuData_q;

  logic          fifoEmpty, hit, pendingHit, miss, accept, push, respStale;
  logic [CW:0]   inFlightSum;
  logic          unusedAddrBits;

  // Words are always aligned, so the low CPU address bits carry no meaning.
  assign unusedAddrBits = ^cpu_address[1:0];

  assign fifoEmpty   = (count_q == '0);
  assign hit         = cpu_read && !fifoEmpty && (tagMem_q[rdPtr_q] == cpu_address[31:2]);
  assign pendingHit  = cpu_read && fifoEmpty && streamValid_q && (fillTag_q == cpu_address[31:2]);
  assign miss        = cpu_read && !hit && !pendingHit;

  // Buffered words plus unanswered reads never exceed DEPTH, so a push
  // always finds a free slot.
  assign inFlightSum = {1'b0, count_q} + {1'b0, outstanding_q};
  assign mem_read    = streamValid_q && (inFlightSum < DEPTH_W);
  assign mem_address = {fetchAddr_q, 2'b00};
  assign accept      = mem_read && !mem_waitrequest;

  // A response that lands in a miss cycle belongs to the abandoned stream.
  assign respStale   = mem_readdatavalid && ((discard_q != '0) || miss);
  assign push        = mem_readdatavalid && (discard_q == '0) && !miss;

  assign cpu_waitrequest   = cpu_read && !hit;
  assign cpu_readdatavalid = cpuValid_q;
  assign cpu_readdata      = cpuData_q;

  // Next-state logic. A miss abandons the stream. Every read still in memory
  // is then owed a drop, which is old discards plus outstanding plus this
  // cycle's acceptance, less the response consumed right now.
  always_comb begin
    rdPtr_d       = rdPtr_q;
    wrPtr_d       = wrPtr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    streamValid_d = streamValid_q;
    fetchAddr_d   = fetchAddr_q;
    fillTag_d     = fillTag_q;
    if (miss) begin
      rdPtr_d       = '0;
      wrPtr_d       = '0;
      count_d       = '0;
      outstanding_d = '0;
      discard_d     = discard_q + outstanding_q + CW'(accept) - CW'(mem_readdatavalid);
      streamValid_d = 1'b1;
      fetchAddr_d   = cpu_address[31:2];
      fillTag_d     = cpu_address[31:2];
    end else begin
      if (accept) begin
        fetchAddr_d = fetchAddr_q + 30'd1;
      end
      if (respStale) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        wrPtr_d   = wrPtr_q + 1'b1;
        fillTag_d = fillTag_q + 30'd1;
      end
      if (hit) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      outstanding_d = outstanding_q + CW'(accept) - CW'(push);
      count_d       = count_q + CW'(push) - CW'(hit);
    end
  end

  // Control state and the registered CPU response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      streamValid_q <= 1'b0;
      fetchAddr_q   <= '0;
      fillTag_q     <= '0;
      cpuValid_q    <= 1'b0;
      cpuData_q     <= '0;
    end else begin
      rdPtr_q       <= rdPtr_d;
      wrPtr_q       <= wrPtr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      streamValid_q <= streamValid_d;
      fetchAddr_q   <= fetchAddr_d;
      fillTag_q     <= fillTag_d;
      cpuValid_q    <= hit;
      if (hit) begin
        cpuData_q <= dataMem_q[rdPtr_q];
      end
    end
  end

  // Queue storage needs no reset. An empty count already hides stale slots.
  always_ff @(posedge clk) begin
    if (push) begin
      tagMem_q[wrPtr_q]  <= fillTag_q;
      dataMem_q[wrPtr_q] <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Self-checking bench for instruction_prefetch_queue. A transaction-level
// model tracks the queue as a list of word addresses and the reads in flight
// as a list of "stale" flags. A small in-order memory with random latency
// answers the design's reads.
module tb_instruction_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_waitrequest;
  logic        cpu_readdatavalid;
  logic [31:0] cpu_readdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic [31:0] mem_readdata;

  instruction_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_address       (cpu_address),
    .cpu_read          (cpu_read),
    .cpu_waitrequest   (cpu_waitrequest),
    .cpu_readdatavalid (cpu_readdatavalid),
    .cpu_readdata      (cpu_readdata),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_readdata      (mem_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          readyAt;
  } memReq_t;

  int          checkCount = 0;
  int          errorCount = 0;
  int          cycleNum = 0;
  int          memLatMin = 1;
  int          memLatMax = 1;
  memReq_t     memQ[$];

  logic [31:0] mFifo[$];
  bit          mStale[$];
  bit          mStream;
  logic [31:0] mFetch;
  logic [31:0] mFill;
  bit          mPrevHit;
  logic [31:0] mPrevAddr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  task automatic modelReset();
    mFifo.delete();
    mStale.delete();
    mStream   = 1'b0;
    mFetch    = '0;
    mFill     = '0;
    mPrevHit  = 1'b0;
    mPrevAddr = '0;
  endtask

  // One reset cycle with memory responses held off, then reset-state checks.
  task automatic applyReset();
    rst               = 1'b1;
    cpu_read          = 1'b0;
    cpu_address       = '0;
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycleNum++;
    memQ.delete();
    modelReset();
    checkOutput("rstCpuValid", 32'(cpu_readdatavalid), 32'd0);
    checkOutput("rstCpuData", cpu_readdata, 32'd0);
    checkOutput("rstMemRead", 32'(mem_read), 32'd0);
  endtask

  // One full clock cycle. Drive inputs, compare outputs against the model,
  // let the memory accept a request, advance the model, step to the next edge.
  task automatic applyStimulus(input bit rd, input logic [31:0] addr, input bit stall,
                               output bit hitSeen);
    bit          hit, pend, miss, expMemRead, s;
    int          live;
    logic [31:0] aligned;
    memReq_t     req;

    cpu_read        = rd;
    cpu_address     = addr;
    mem_waitrequest = stall;
    if (memQ.size() > 0 && memQ[0].readyAt <= cycleNum) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = memWord(memQ[0].addr);
      memQ.delete(0);
    end else begin
      mem_readdatavalid = 1'b0;
      mem_readdata      = $urandom;
    end
    #1;

    aligned = {addr[31:2], 2'b00};
    live = 0;
    foreach (mStale[i]) if (!mStale[i]) live++;
    expMemRead = mStream && ((mFifo.size() + live) < DEPTH);
    hit  = rd && (mFifo.size() > 0) && (mFifo[0] == aligned);
    pend = rd && (mFifo.size() == 0) && mStream && (mFill == aligned);
    miss = rd && !hit && !pend;

    checkOutput("memRead", 32'(mem_read), 32'(expMemRead));
    if (expMemRead) checkOutput("memAddress", mem_address, mFetch);
    checkOutput("cpuWait", 32'(cpu_waitrequest), 32'(rd && !hit));
    checkOutput("cpuValid", 32'(cpu_readdatavalid), 32'(mPrevHit));
    if (mPrevHit) checkOutput("cpuData", cpu_readdata, memWord(mPrevAddr));
    hitSeen = rd && (cpu_waitrequest == 1'b0);

    if (mem_read && !stall) begin
      req.addr    = mem_address;
      req.readyAt = cycleNum + memLatMin + int'($urandom_range(memLatMax - memLatMin, 0));
      memQ.push_back(req);
    end

    if (mem_readdatavalid && mStale.size() > 0) begin
      s = mStale.pop_front();
      if (!s && !miss) begin
        mFifo.push_back(mFill);
        mFill += 32'd4;
      end
    end
    if (hit) void'(mFifo.pop_front());
    if (expMemRead && !stall) begin
      mStale.push_back(1'b0);
      mFetch += 32'd4;
    end
    if (miss) begin
      mFifo.delete();
      foreach (mStale[i]) mStale[i] = 1'b1;
      mFetch  = aligned;
      mFill   = aligned;
      mStream = 1'b1;
    end
    mPrevHit  = hit;
    mPrevAddr = aligned;

    @(posedge clk);
    #1;
    cycleNum++;
  endtask

  // CPU walks sequential words from start until nHits fetches are accepted.
  task automatic streamRun(input logic [31:0] start, input int nHits, input int stallPct,
                           output int cycles);
    logic [31:0] addr;
    int          hits;
    bit          seen;
    addr   = start;
    hits   = 0;
    cycles = 0;
    while (hits < nHits && cycles < 400) begin
      applyStimulus(1'b1, addr, (int'($urandom_range(99, 0)) < stallPct), seen);
      cycles++;
      if (seen) begin
        hits++;
        addr += 32'd4;
      end
    end
    checkOutput("streamHits", hits, nHits);
  endtask

  function automatic logic [31:0] randomTarget();
    logic [31:0] r;
    r = $urandom;
    case (r[31:30])
      2'd0:    return r & 32'h0000_03FF;
      2'd1:    return 32'hFFFF_FFF0 | (r & 32'h0000_000F);
      2'd2:    return 32'h0000_0100;
      default: return r;
    endcase
  endfunction

  initial begin
    int          cyc, firstValid, firstMemRead, n;
    bit          seen, rd, stall;
    logic [31:0] addr;

    rst = 1'b1;
    cpu_read = 1'b0;
    cpu_address = '0;
    mem_waitrequest = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata = '0;
    modelReset();

    // Cold start, fetch of word 0 held, single-cycle memory.
    applyReset();
    firstValid = -1;
    firstMemRead = -1;
    for (int c = 0; c < 8; c++) begin
      if (cpu_readdatavalid === 1'b1 && firstValid < 0) firstValid = c;
      if (mem_read === 1'b1 && firstMemRead < 0) firstMemRead = c;
      applyStimulus(1'b1, 32'h0, 1'b0, seen);
    end
    checkOutput("coldFirstMemRead", firstMemRead, 32'd1);
    checkOutput("coldFirstValid", firstValid, 32'd4);

    // Back-to-back sequential stream 0x0..0x3C.
    applyReset();
    streamRun(32'h0, 16, 0, cyc);
    checkOutput("streamCycles", cyc, 32'd19);

    // Branch with three reads owed: latency 3 makes the responses stale.
    applyReset();
    memLatMin = 3;
    memLatMax = 3;
    applyStimulus(1'b1, 32'h0, 1'b0, seen);
    applyStimulus(1'b0, 32'h0, 1'b0, seen);
    applyStimulus(1'b0, 32'h0, 1'b0, seen);
    streamRun(32'h100, 1, 0, cyc);
    checkOutput("branchCycles", cyc, 32'd6);
    checkOutput("branchData", cpu_readdata, memWord(32'h100));
    applyStimulus(1'b0, 32'h0, 1'b0, seen);

    // Memory stalls for five cycles during fill.
    applyReset();
    memLatMin = 1;
    memLatMax = 1;
    applyStimulus(1'b1, 32'h200, 1'b0, seen);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 32'h0, 1'b1, seen);
    streamRun(32'h200, 8, 0, cyc);

    // Stream across the top of the address space.
    applyReset();
    streamRun(32'hFFFF_FFF8, 4, 0, cyc);
    checkOutput("wrapCycles", cyc, 32'd7);

    // Reset while the queue holds two words, then restart at 0x4.
    applyReset();
    applyStimulus(1'b1, 32'h40, 1'b0, seen);
    n = 0;
    while (mFifo.size() != 2 && n < 10) begin
      applyStimulus(1'b0, 32'h0, 1'b0, seen);
      n++;
    end
    applyReset();
    streamRun(32'h4, 4, 0, cyc);
    checkOutput("restartCycles", cyc, 32'd7);

    // Random traffic: branches, idle cycles, stalls, variable latency, resets.
    memLatMin = 1;
    memLatMax = 3;
    addr = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499, 0) == 0) begin
        applyReset();
      end else begin
        rd    = ($urandom_range(7, 0) != 0);
        stall = ($urandom_range(3, 0) == 0);
        if ($urandom_range(11, 0) == 0) addr = randomTarget();
        applyStimulus(rd, addr, stall, seen);
        if (seen) addr += 32'd4;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
